// File: rtl/tape_pkg.sv
// Shared types and sizing for the cassette tape encoder.
package tape_pkg;

  typedef enum logic [2:0] {IDLE, PILOT, SYNC, DATA, TAIL, DONE} tape_state_t;

  localparam int CELL_W  = 24;  // cell timer; covers any practical HALF_BIT
  localparam int PILOT_W = 16;  // pilot byte counter, PILOT_BYTES up to 65535
  localparam int TAIL_W  = 16;  // tail half-cell counter
  localparam int ENTRY_W = 9;   // FIFO entry {last, data}

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Turbo half-cell length: a quarter of the normal cell, never below 2 cycles.
  function automatic int turbo_len(input int half);
    return (half / 4 < 2) ? 2 : half / 4;
  endfunction

endpackage

// File: rtl/tape_fifo.sv
// Synchronous FIFO of {last,data} entries with registered-count full/empty flags.
module tape_fifo
  import tape_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               wr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_wr;
  logic               do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr & ~full;
  assign do_rd   = rd & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk_sys) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tape_player.sv
// Radio-86RK/Apogee bi-phase tape encoder: pilot, sync byte, buffered payload, tail.
// Optional macro TAPE_TURBO_EN adds a `turbo` input selecting quarter-length cells.
module tape_player
  import tape_pkg::*;
#(
  parameter int         HALF_BIT    = 21600,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         PILOT_BYTES = 256,
  parameter logic [7:0] SYNC_BYTE   = 8'hE6,
  parameter int         TAIL_CELLS  = 16
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       start,
`ifdef TAPE_TURBO_EN
  input  logic       turbo,
`endif
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tape_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [CELL_W-1:0]  HALF_LEN   = CELL_W'(HALF_BIT);
  localparam logic [PILOT_W-1:0] PILOT_LAST = PILOT_W'(PILOT_BYTES - 1);
  localparam logic [TAIL_W-1:0]  TAIL_LAST  = TAIL_W'(TAIL_CELLS - 1);

  tape_state_t        state;
  logic [CELL_W-1:0]  timer;
  logic [CELL_W-1:0]  period;
  logic [CELL_W-1:0]  period_sel;
  logic [PILOT_W-1:0] pilot_cnt;
  logic [TAIL_W-1:0]  tail_cnt;
  logic [7:0]         shreg;
  logic [2:0]         bit_cnt;
  logic               phase;
  logic               cur_last;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               cell_wrap;
  logic               byte_end;
  logic               start_ok;
  logic [7:0]         next_byte;
  logic               next_last;

  tape_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .wr      (in_valid),
    .wr_data ({in_last, in_data}),
    .rd      (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready = ~fifo_full;

`ifdef TAPE_TURBO_EN
  assign period_sel = turbo ? CELL_W'(turbo_len(HALF_BIT)) : HALF_LEN;
`else
  assign period_sel = HALF_LEN;
`endif

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign cell_wrap = (state inside {PILOT, SYNC, DATA, TAIL}) && (timer == period - CELL_W'(1));
  assign byte_end  = (state inside {PILOT, SYNC, DATA}) && cell_wrap && phase && (bit_cnt == 3'd7);
  // Payload fetch happens at the end of SYNC and of every non-final DATA byte.
  assign pop       = byte_end && (state == SYNC || (state == DATA && !cur_last)) && !fifo_empty;

  // Byte that follows the current one; an empty FIFO during payload yields 8'h00.
  always_comb begin
    next_byte = 8'h00;
    next_last = 1'b0;
    case (state)
      PILOT:     if (pilot_cnt == PILOT_LAST) next_byte = SYNC_BYTE;
      SYNC, DATA: if (!fifo_empty) {next_last, next_byte} = head;
      default:   ;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      period    <= HALF_LEN;
      pilot_cnt <= '0;
      tail_cnt  <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      cur_last  <= 1'b0;
      tape_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state     <= PILOT;
            busy      <= 1'b1;
            underrun  <= 1'b0;
            timer     <= '0;
            period    <= period_sel;
            pilot_cnt <= '0;
            shreg     <= 8'h00;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            cur_last  <= 1'b0;
            tape_out  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        PILOT, SYNC, DATA: begin
          if (!cell_wrap) begin
            timer <= timer + CELL_W'(1);
          end else begin
            timer <= '0;
            if (!phase) begin
              phase    <= 1'b1;
              tape_out <= shreg[7];
            end else if (!byte_end) begin
              phase    <= 1'b0;
              bit_cnt  <= bit_cnt + 3'd1;
              shreg    <= {shreg[6:0], 1'b0};
              tape_out <= ~shreg[6];
            end else begin
              phase   <= 1'b0;
              bit_cnt <= '0;
              period  <= period_sel;
              if (state == DATA && cur_last) begin
                state    <= TAIL;
                tail_cnt <= '0;
                tape_out <= 1'b0;
              end else begin
                shreg    <= next_byte;
                cur_last <= next_last;
                tape_out <= ~next_byte[7];
                if (state == PILOT) begin
                  pilot_cnt <= pilot_cnt + PILOT_W'(1);
                  if (pilot_cnt == PILOT_LAST) state <= SYNC;
                end else begin
                  state <= DATA;
                  if (fifo_empty) underrun <= 1'b1;
                end
              end
            end
          end
        end

        TAIL: begin
          if (!cell_wrap) begin
            timer <= timer + CELL_W'(1);
          end else begin
            timer <= '0;
            if (tail_cnt == TAIL_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              tail_cnt <= tail_cnt + TAIL_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player (HALF_BIT=4, PILOT_BYTES=2, TAIL_CELLS=4); decodes tape_out.
module tb_tape_player;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       tape_out;
  logic       busy;
  logic       done;
  logic       underrun;
`ifdef TAPE_TURBO_EN
  logic       turbo;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  tape_player #(
    .HALF_BIT    (4),
    .FIFO_DEPTH  (16),
    .PILOT_BYTES (2),
    .SYNC_BYTE   (8'hE6),
    .TAIL_CELLS  (4)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .start    (start),
`ifdef TAPE_TURBO_EN
    .turbo    (turbo),
`endif
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tape_out (tape_out),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic push(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk_sys);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Leaves the bench at the negedge after the accepting edge: first cycle of the pilot.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  // Samples one half-cell of len cycles starting at its first cycle.
  task automatic read_half(input int len, output logic v, output bit stable);
    v      = tape_out;
    stable = 1'b1;
    for (int c = 1; c < len; c++) begin
      @(negedge clk_sys);
      if (tape_out !== v) stable = 1'b0;
    end
    @(negedge clk_sys);
  endtask

  // Decodes one byte; ok clears on a split cell or a pair that is not complementary.
  task automatic read_byte(input int len, output logic [7:0] b, output bit ok);
    logic a, d;
    bit   s1, s2;
    ok = 1'b1;
    b  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_half(len, a, s1);
      read_half(len, d, s2);
      b = {b[6:0], d};
      if (!s1 || !s2 || a !== ~d) ok = 1'b0;
    end
  endtask

  // Counts cycles from tail entry until done, and cycles where tape_out was not low.
  task automatic wait_done(output int cyc, output int highs);
    cyc   = 0;
    highs = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (tape_out !== 1'b0) highs++;
      @(negedge clk_sys);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
`ifdef TAPE_TURBO_EN
    turbo    = 1'b0;
`endif
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if ({tape_out, busy, done, underrun, in_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_outputs: got {tape,busy,done,underrun,ready}=%b, want 00001",
               {tape_out, busy, done, underrun, in_ready});
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [5] = '{8'h00, 8'h00, 8'hE6, 8'hA5, 8'h3C};
    logic [7:0] b;
    bit         ok;
    int         cyc, highs;
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b1);
    pulse_start();
    n_cmp++;
    if ({busy, tape_out} !== 2'b11) begin
      n_bad++;
      $display("FAIL basic_first_cycle: got busy=%b tape=%b, want 1 1", busy, tape_out);
    end
    for (int i = 0; i < 5; i++) begin
      read_byte(4, b, ok);
      n_cmp++;
      if (!ok || b !== exp_b[i]) begin
        n_bad++;
        $display("FAIL basic_byte%0d: got %h (clean=%0d), want %h", i, b, ok, exp_b[i]);
      end
    end
    wait_done(cyc, highs);
    n_cmp++;
    if (cyc != 16 || highs != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_tail: got cycles=%0d highs=%0d busy=%b, want 16 0 0", cyc, highs, busy);
    end
    @(negedge clk_sys);
    n_cmp++;
    if ({done, underrun} !== 2'b00) begin
      n_bad++;
      $display("FAIL basic_done_pulse: got done=%b underrun=%b, want 0 0", done, underrun);
    end
  endtask

  task automatic test_bit_one();
    logic [7:0] b;
    bit         ok, s;
    logic       v;
    int         cyc, highs;
    push(8'h80, 1'b1);
    pulse_start();
    for (int i = 0; i < 3; i++) read_byte(4, b, ok);
    n_cmp++;
    if (!ok || b !== 8'hE6) begin
      n_bad++;
      $display("FAIL bit1_sync: got %h (clean=%0d), want e6", b, ok);
    end
    read_half(4, v, s);
    n_cmp++;
    if (!s || v !== 1'b0) begin
      n_bad++;
      $display("FAIL bit1_first_half: got level=%b stable=%0d, want 0 1", v, s);
    end
    read_half(4, v, s);
    n_cmp++;
    if (!s || v !== 1'b1) begin
      n_bad++;
      $display("FAIL bit1_second_half: got level=%b stable=%0d, want 1 1", v, s);
    end
    for (int i = 0; i < 14; i++) read_half(4, v, s);
    wait_done(cyc, highs);
    n_cmp++;
    if (cyc != 16 || highs != 0) begin
      n_bad++;
      $display("FAIL bit1_tail: got cycles=%0d highs=%0d, want 16 0", cyc, highs);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_fifo_full();
    logic [7:0] b;
    bit         ok;
    int         cyc, highs;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      in_last  = (i == 15);
      @(negedge clk_sys);
    end
    in_data = 8'hFF;
    in_last = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_ready: got in_ready=%b, want 0", in_ready);
    end
    @(negedge clk_sys);
    in_valid = 1'b0;
    in_last  = 1'b0;
    pulse_start();
    fork
      begin
        repeat (10) @(negedge clk_sys);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
      end
      begin
        read_byte(4, b, ok);
        n_cmp++;
        if (!ok || b !== 8'h00) begin
          n_bad++;
          $display("FAIL full_pilot0: got %h (clean=%0d), want 00", b, ok);
        end
      end
    join
    read_byte(4, b, ok);
    read_byte(4, b, ok);
    n_cmp++;
    if (!ok || b !== 8'hE6) begin
      n_bad++;
      $display("FAIL full_sync: got %h (clean=%0d), want e6 (start while busy must be ignored)", b, ok);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL full_ready_after_pop: got in_ready=%b, want 1", in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      read_byte(4, b, ok);
      n_cmp++;
      if (!ok || b !== 8'h10 + 8'(i)) begin
        n_bad++;
        $display("FAIL full_order%0d: got %h (clean=%0d), want %h", i, b, ok, 8'h10 + 8'(i));
      end
    end
    wait_done(cyc, highs);
    n_cmp++;
    if (cyc != 16 || highs != 0) begin
      n_bad++;
      $display("FAIL full_tail: got cycles=%0d highs=%0d, want 16 0", cyc, highs);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_underrun();
    logic [7:0] b;
    bit         ok;
    int         cyc, highs;
    pulse_start();
    for (int i = 0; i < 3; i++) read_byte(4, b, ok);
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_set: got underrun=%b, want 1", underrun);
    end
    fork
      push(8'h11, 1'b1);
      read_byte(4, b, ok);
    join
    n_cmp++;
    if (!ok || b !== 8'h00) begin
      n_bad++;
      $display("FAIL underrun_filler: got %h (clean=%0d), want 00", b, ok);
    end
    read_byte(4, b, ok);
    n_cmp++;
    if (!ok || b !== 8'h11 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_payload: got %h (clean=%0d) busy=%b, want 11 busy=1", b, ok, busy);
    end
    wait_done(cyc, highs);
    n_cmp++;
    if (cyc != 16 || highs != 0 || underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_tail: got cycles=%0d highs=%0d underrun=%b, want 16 0 1", cyc, highs, underrun);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [4] = '{8'h00, 8'h00, 8'hE6, 8'h77};
    logic [7:0] b;
    bit         ok;
    int         cyc, highs;
    push(8'h5A, 1'b0);
    push(8'hC3, 1'b1);
    pulse_start();
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_clears_underrun: got underrun=%b, want 0", underrun);
    end
    for (int i = 0; i < 3; i++) read_byte(4, b, ok);
    n_cmp++;
    if ({tape_out, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL midreset_pre: got tape=%b busy=%b, want 1 1", tape_out, busy);
    end
    reset_n = 1'b0;
    @(negedge clk_sys);
    n_cmp++;
    if ({tape_out, busy, in_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL midreset_outputs: got tape=%b busy=%b ready=%b, want 0 0 1", tape_out, busy, in_ready);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    push(8'h77, 1'b1);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      read_byte(4, b, ok);
      n_cmp++;
      if (!ok || b !== exp_b[i]) begin
        n_bad++;
        $display("FAIL midreset_replay%0d: got %h (clean=%0d), want %h", i, b, ok, exp_b[i]);
      end
    end
    wait_done(cyc, highs);
    n_cmp++;
    if (cyc != 16 || highs != 0) begin
      n_bad++;
      $display("FAIL midreset_tail: got cycles=%0d highs=%0d, want 16 0", cyc, highs);
    end
    @(negedge clk_sys);
  endtask

`ifdef TAPE_TURBO_EN
  task automatic test_turbo();
    logic [7:0] exp_b [3] = '{8'h00, 8'hE6, 8'h96};
    logic [7:0] b;
    bit         ok;
    int         cyc, highs;
    push(8'h96, 1'b1);
    turbo = 1'b1;
    pulse_start();
    fork
      begin
        repeat (6) @(negedge clk_sys);
        turbo = 1'b0;
      end
      read_byte(2, b, ok);
    join
    n_cmp++;
    if (!ok || b !== 8'h00) begin
      n_bad++;
      $display("FAIL turbo_byte0: got %h (clean=%0d), want 00 at 2-cycle cells", b, ok);
    end
    for (int i = 0; i < 3; i++) begin
      read_byte(4, b, ok);
      n_cmp++;
      if (!ok || b !== exp_b[i]) begin
        n_bad++;
        $display("FAIL turbo_byte%0d: got %h (clean=%0d), want %h at 4-cycle cells", i + 1, b, ok, exp_b[i]);
      end
    end
    wait_done(cyc, highs);
    n_cmp++;
    if (cyc != 16 || highs != 0) begin
      n_bad++;
      $display("FAIL turbo_tail: got cycles=%0d highs=%0d, want 16 0", cyc, highs);
    end
    @(negedge clk_sys);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bit_one();
    test_fifo_full();
    test_underrun();
    test_reset_mid();
`ifdef TAPE_TURBO_EN
    test_turbo();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
